accelerator_trainer_vector_differentiation: RTL

Streaming time-differentiation stage of the NTM trainer. Accepts a time series of vectors, one element per strobe, and emits the scaled first difference of each element against the same element one time step earlier. Its outputs feed the trainer's weight-update datapath (W/K/U/B gradient terms) and its block-level testbench stimulus. The period scale is a power of two, applied as an arithmetic right shift.

---
 rtl/accelerator_trainer_pkg.sv | 22 ++
 rtl/accelerator_trainer_vector_differentiation_if.sv | 33 +++
 rtl/accelerator_trainer_vector_buffer.sv | 37 +++
 rtl/accelerator_trainer_vector_differentiation.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/accelerator_trainer_pkg.sv
// ---------------------------------------------------------------------------
// accelerator_trainer_pkg
// Shared definitions for the NTM trainer datapath blocks: FSM state encoding,
// default widths and the zero/one constants used by counters and datapaths.
// ---------------------------------------------------------------------------
package accelerator_trainer_pkg;

  localparam int DEFAULT_DATA_SIZE    = 64;
  localparam int DEFAULT_CONTROL_SIZE = 64;
  localparam int DEFAULT_SIZE_MAX     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DEFAULT_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
  localparam logic [DEFAULT_CONTROL_SIZE-1:0] ONE_CONTROL  = DEFAULT_CONTROL_SIZE'(1);
  localparam logic [DEFAULT_DATA_SIZE-1:0]    ZERO_DATA    = '0;

endpackage : accelerator_trainer_pkg

// File: rtl/accelerator_trainer_vector_differentiation_if.sv
// ---------------------------------------------------------------------------
// accelerator_trainer_vector_differentiation_if
// Control and streaming bus of the vector differentiation stage.
//   master : drives start, run configuration and the input element stream
//   slave  : the differentiation stage; returns the difference stream and
//            the end-of-run ready pulse
// ---------------------------------------------------------------------------
interface accelerator_trainer_vector_differentiation_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);

  logic                    start;
  logic                    ready;
  logic                    data_in_enable;
  logic                    data_out_enable;
  logic [CONTROL_SIZE-1:0] size_i_in;
  logic [CONTROL_SIZE-1:0] length_in;
  logic [CONTROL_SIZE-1:0] shift_in;
  logic [DATA_SIZE-1:0]    data_in;
  logic [DATA_SIZE-1:0]    data_out;

  modport master (
    output start, data_in_enable, size_i_in, length_in, shift_in, data_in,
    input  ready, data_out_enable, data_out
  );

  modport slave (
    input  start, data_in_enable, size_i_in, length_in, shift_in, data_in,
    output ready, data_out_enable, data_out
  );

endinterface : accelerator_trainer_vector_differentiation_if

// File: rtl/accelerator_trainer_vector_buffer.sv
// ---------------------------------------------------------------------------
// accelerator_trainer_vector_buffer
// SIZE_MAX x DATA_SIZE register file holding the previous time step's vector.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : asynchronous read address
//   rdata  : read data; a same-cycle write to raddr is not yet visible
// ---------------------------------------------------------------------------
module accelerator_trainer_vector_buffer #(
  parameter int DATA_SIZE = 64,
  parameter int SIZE_MAX  = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [SIZE_MAX];

  // NOTE: the storage array has no reset; contents are only ever consumed
  // after being written during the current run, and a reset port on a
  // memory would stop it mapping onto RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < SIZE_MAX)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < SIZE_MAX) ? mem[raddr] : '0;

endmodule : accelerator_trainer_vector_buffer

// File: rtl/accelerator_trainer_vector_differentiation.sv
// ---------------------------------------------------------------------------
// accelerator_trainer_vector_differentiation
// Streaming first-difference stage of the NTM trainer. Each accepted element
// x[t][i] yields d[t][i] = (x[t][i] - x[t-1][i]) >>> shift, and 0 for t = 0.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of the stage bus
//          start            begin a run (IDLE only)
//          size_i_in        elements per vector (clamped to SIZE_MAX)
//          length_in        time steps per run
//          shift_in         right-shift amount, low 6 bits used
//          data_in_enable   data_in valid
//          data_in          element x[t][i]
//          data_out_enable  data_out valid, one cycle after data_in_enable
//          data_out         element d[t][i], held while not enabled
//          ready            one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module accelerator_trainer_vector_differentiation
  import accelerator_trainer_pkg::*;
#(
  parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
  parameter int CONTROL_SIZE = DEFAULT_CONTROL_SIZE,
  parameter int SIZE_MAX     = DEFAULT_SIZE_MAX
) (
  input logic clk,
  input logic rst,
  accelerator_trainer_vector_differentiation_if.slave bus
);

  localparam int ADDR_W = (SIZE_MAX > 1) ? $clog2(SIZE_MAX) : 1;

  localparam logic [1:0] STATE_IDLE = 2'(IDLE);
  localparam logic [1:0] STATE_RUN  = 2'(RUN);
  localparam logic [1:0] STATE_DONE = 2'(DONE);

  localparam logic [CONTROL_SIZE-1:0] ZERO_C     = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] ONE_C      = CONTROL_SIZE'(ONE_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] SIZE_MAX_C = CONTROL_SIZE'(SIZE_MAX);
  localparam logic [DATA_SIZE-1:0]    ZERO_D     = DATA_SIZE'(ZERO_DATA);

  logic [1:0]              state_q;
  logic [CONTROL_SIZE-1:0] size_q;
  logic [CONTROL_SIZE-1:0] length_q;
  logic [5:0]              shift_q;
  logic [CONTROL_SIZE-1:0] i_q;
  logic [CONTROL_SIZE-1:0] t_q;
  logic [DATA_SIZE-1:0]    data_out_q;
  logic                    data_out_enable_q;
  logic                    ready_q;

  logic                    accept;
  logic                    last_i;
  logic                    last_t;
  logic [DATA_SIZE-1:0]    prev_data;
  logic signed [DATA_SIZE-1:0] diff;
  logic signed [DATA_SIZE-1:0] shifted;
  logic [CONTROL_SIZE-1:0] size_clamped;
  logic                    empty_run;

  // -------------------------------------------------------------------------
  // Previous-vector storage; read and write share the element index, and the
  // read returns the value from the previous time step.
  // -------------------------------------------------------------------------
  accelerator_trainer_vector_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_MAX  (SIZE_MAX),
    .ADDR_W    (ADDR_W)
  ) u_buffer (
    .clk   (clk),
    .we    (accept),
    .waddr (i_q[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .raddr (i_q[ADDR_W-1:0]),
    .rdata (prev_data)
  );

  assign accept = (state_q == STATE_RUN) && bus.data_in_enable;
  assign last_i = (i_q == size_q - ONE_C);
  assign last_t = (t_q == length_q - ONE_C);

  // Wrapping two's-complement difference, then arithmetic shift (floors
  // toward minus infinity for negative differences).
  assign diff    = bus.data_in - prev_data;
  assign shifted = diff >>> shift_q;

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    size_clamped = bus.size_i_in;
    empty_run    = 1'b0;
    if (bus.size_i_in > SIZE_MAX_C) begin
      size_clamped = SIZE_MAX_C;
    end
    if ((size_clamped == ZERO_C) || (bus.length_in == ZERO_C)) begin
      empty_run = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= STATE_IDLE;
      size_q            <= ZERO_C;
      length_q          <= ZERO_C;
      shift_q           <= '0;
      i_q               <= ZERO_C;
      t_q               <= ZERO_C;
      data_out_q        <= ZERO_D;
      data_out_enable_q <= 1'b0;
      ready_q           <= 1'b0;
    end else begin
      data_out_enable_q <= accept;
      ready_q           <= 1'b0;

      if (accept) begin
        data_out_q <= (t_q == ZERO_C) ? ZERO_D : DATA_SIZE'(shifted);
      end

      case (state_q)
        STATE_IDLE: begin
          if (bus.start) begin
            size_q   <= size_clamped;
            length_q <= bus.length_in;
            shift_q  <= bus.shift_in[5:0];
            i_q      <= ZERO_C;
            t_q      <= ZERO_C;
            state_q  <= empty_run ? STATE_DONE : STATE_RUN;
          end
        end

        STATE_RUN: begin
          if (accept) begin
            if (last_i) begin
              i_q <= ZERO_C;
              t_q <= t_q + ONE_C;
              if (last_t) begin
                // Ready rises together with the final output.
                state_q <= STATE_DONE;
                ready_q <= 1'b1;
              end
            end else begin
              i_q <= i_q + ONE_C;
            end
          end
        end

        STATE_DONE: begin
          // A completed run arrives here with ready already high and drops
          // it; an empty run arrives with ready low and raises it now, which
          // places its pulse two cycles after start.
          ready_q <= ~ready_q;
          state_q <= STATE_IDLE;
        end

        default: begin
          state_q <= STATE_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out        = data_out_q;
  assign bus.data_out_enable = data_out_enable_q;
  assign bus.ready           = ready_q;

endmodule : accelerator_trainer_vector_differentiation
